deserializer_out: RTL and testbench

//  Serial receiver that sits directly downstream of the serializer link.
//  - Samples a 1-bit line, frames it, and rebuilds three 9-bit symbols [k + 8 bits] (k=1 kcode, k=0 data).
//  - Presents the word on a valid/ready output buffer for the bus-side capture logic.
//  - Flags framing errors and overruns.

---
 rtl/deserializer_out_if.sv | 37 +++
 rtl/deserializer_out.sv | 180 ++++++++++++++++++
 tb/tb_deserializer_out.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer_out_if
//  Description : Output-buffer bus of the serial deserializer. The receiver
//                is the master: it presents a rebuilt frame word together
//                with its per-symbol k flags and a valid flag; the consumer
//                (slave) answers with ready.
//  Signals     : data_o  [OUT_W] frame word {zeros, sym[NSYM-1] .. sym[0]}
//                kflag_o [NSYM]  k bit of each symbol
//                valid_o         buffer holds an unread frame
//                ready_i         consumer accepts (transfer on valid & ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface deserializer_out_if #(
    parameter int NSYM  = 3,
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] data_o;
    logic [NSYM-1:0]  kflag_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        output data_o,
        output kflag_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  kflag_o,
        input  valid_o,
        output ready_i
    );
endinterface
`default_nettype wire

// File: rtl/deserializer_out.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer_out
//  Description : Serial receiver for the serializer link. Frames a 1-bit
//                line (start '1', NSYM*SYM_W data bits MSB first, optional
//                even-parity bit, stop '0'), rebuilds NSYM symbols of
//                {k, 8 data bits} and offers them on a valid/ready buffer.
//                Bad stop bit (or bad parity) pulses frame_err_o; a good
//                frame arriving while the buffer is full and unread is
//                dropped and pulses ovr_o.
//  Options     : DESER_PARITY_CHECK_EN - adds a parity bit after the data
//                bits and rejects frames whose even parity does not match.
//  Ports       : clk_i        clock, line sampled on every rising edge
//                rst_i        asynchronous reset, active low
//                data_i       serial line (idles low)
//                bus          deserializer_out_if master (data/kflag/valid/ready)
//                busy_o       receiver is inside a frame
//                frame_err_o  1-cycle framing/parity error pulse
//                ovr_o        1-cycle overrun pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializer_out #(
    parameter int NSYM  = 3,
    parameter int SYM_W = 9,
    parameter int OUT_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              data_i,
    deserializer_out_if.master     bus,
    output logic                   busy_o,
    output logic                   frame_err_o,
    output logic                   ovr_o
);

    localparam int DATA_W = NSYM * SYM_W;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef DESER_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [OUT_W-1:0]   data_q,  data_d;
    logic [NSYM-1:0]    kflag_q, kflag_d;
    logic               valid_q, valid_d;
    logic               err_q,   err_d;
    logic               ovr_q,   ovr_d;
    logic               par_bad;
    logic [NSYM-1:0]    shreg_kflag;

`ifdef DESER_PARITY_CHECK_EN
    logic               par_q, par_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = (^shreg_q) ^ par_q;
`else
    assign par_bad = 1'b0;
`endif

    // The k flag is the top bit of each symbol slice.
    generate
        for (genvar i = 0; i < NSYM; i++) begin : g_kflag
            assign shreg_kflag[i] = shreg_q[i*SYM_W + SYM_W - 1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            kflag_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            kflag_q <= kflag_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
`ifdef DESER_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        kflag_d = kflag_q;
        // A transfer this cycle empties the buffer unless a commit refills it.
        valid_d = valid_q & ~bus.ready_i;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
`ifdef DESER_PARITY_CHECK_EN
        par_d   = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (data_i) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end

            S_SHIFT: begin
                shreg_d = {shreg_q[DATA_W-2:0], data_i};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef DESER_PARITY_CHECK_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end
            end

`ifdef DESER_PARITY_CHECK_EN
            S_PAR: begin
                par_d   = data_i;
                state_d = S_STOP;
            end
`endif

            S_STOP: begin
                // Back to IDLE unconditionally: a '1' stop bit is an error,
                // never a start bit.
                state_d = S_IDLE;
                if (data_i || par_bad) begin
                    err_d = 1'b1;
                end else if (!valid_q || bus.ready_i) begin
                    data_d  = OUT_W'(shreg_q);
                    kflag_d = shreg_kflag;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.data_o  = data_q;
    assign bus.kflag_o = kflag_q;
    assign bus.valid_o = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_err_o = err_q;
    assign ovr_o       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer_out
//  Description : Scoreboard bench for deserializer_out. A driver serialises
//                frames and announces each stop bit; a reference model keeps
//                the expected buffer contents in a queue; a monitor compares
//                DUT outputs every cycle on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer_out;

    localparam int NSYM  = 3;
    localparam int SYM_W = 9;
    localparam int OUT_W = 32;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [NSYM-1:0]  k;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic data_i = 1'b0;
    logic busy, ferr, ovr;

    deserializer_out_if #(.NSYM(NSYM), .OUT_W(OUT_W)) bus ();

    deserializer_out #(.NSYM(NSYM), .SYM_W(SYM_W), .OUT_W(OUT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .data_i      (data_i),
        .bus         (bus.master),
        .busy_o      (busy),
        .frame_err_o (ferr),
        .ovr_o       (ovr)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;

    // Driver -> model announcements, valid for the bit currently on the line.
    logic        line_busy = 1'b0;
    logic        ev_stop   = 1'b0;
    logic        ev_good   = 1'b0;
    logic [26:0] ev_word   = '0;
    logic        rand_ready = 1'b0;

    // Reference model state.
    exp_t exp_q[$];
    logic mdl_full = 1'b0;
    logic exp_err  = 1'b0;
    logic exp_ovr  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor + model: compare this cycle, then predict the next one.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic read;
        exp_t e;
        if (!rst_n) begin
            mdl_full = 1'b0;
            exp_err  = 1'b0;
            exp_ovr  = 1'b0;
            exp_q.delete();
        end
        chk("valid", 32'(bus.valid_o), 32'(mdl_full));
        chk("busy",  32'(busy),        32'(line_busy));
        chk("ferr",  32'(ferr),        32'(exp_err));
        chk("ovr",   32'(ovr),         32'(exp_ovr));
        if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(bus.valid_o), 32'd0);
            end else begin
                chk("data",  bus.data_o,          exp_q[0].d);
                chk("kflag", 32'(bus.kflag_o),    32'(exp_q[0].k));
            end
        end
        if (rst_n) begin
            read = mdl_full && bus.ready_i;
            if (read && exp_q.size() > 0) void'(exp_q.pop_front());
            exp_err = ev_stop && !ev_good;
            exp_ovr = 1'b0;
            if (ev_stop && ev_good) begin
                if (!mdl_full || bus.ready_i) begin
                    e.d = {5'b0, ev_word};
                    e.k = {ev_word[26], ev_word[17], ev_word[8]};
                    exp_q.push_back(e);
                    mdl_full = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (read) begin
                mdl_full = 1'b0;
            end
        end
    end

    // Random consumer, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic drive_bit(input logic b, input logic bsy, input logic stp,
                             input logic good, input logic [26:0] w);
        @(posedge clk);
        #1;
        data_i    = b;
        line_busy = bsy;
        ev_stop   = stp;
        ev_good   = good;
        ev_word   = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [8:0] s2, input logic [8:0] s1,
                              input logic [8:0] s0, input logic stop_bit,
                              input logic flip);
        logic [26:0] w;
        logic        good;
        w = {s2, s1, s0};
        drive_bit(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 26; i >= 0; i--) drive_bit(w[i], 1'b1, 1'b0, 1'b0, '0);
`ifdef DESER_PARITY_CHECK_EN
        drive_bit((^w) ^ flip, 1'b1, 1'b0, 1'b0, '0);
        good = !stop_bit && !flip;
`else
        good = !stop_bit && (flip || !flip);
`endif
        drive_bit(stop_bit, 1'b1, 1'b1, good, w);
    endtask

    // Directed check of the buffer one cycle after the last stop bit.
    task automatic expect_out(input string nm, input logic [31:0] d, input logic [2:0] k);
        idle(1);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.valid_o), 32'd1);
        chk({nm, "_data"},  bus.data_o,       d);
        chk({nm, "_kflag"}, 32'(bus.kflag_o), 32'(k));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.ready_i = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Reset state with the line idle.
        idle(20);
        @(negedge clk);
        chk("rst_data",  bus.data_o,       32'd0);
        chk("rst_kflag", 32'(bus.kflag_o), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);

        // Basic frame with a kcode in the top symbol.
        send_frame(9'h1BC, 9'h0AA, 9'h055, 1'b0, 1'b0);
        expect_out("t2", 32'h06F1_5455, 3'b100);
        idle(3);

        // Bad stop bit followed directly by a good frame.
        send_frame(9'h1BC, 9'h0AA, 9'h055, 1'b1, 1'b0);
        idle(2);
        send_frame(9'h012, 9'h134, 9'h056, 1'b0, 1'b0);
        idle(4);

        // Consumer stalled: second back-to-back frame overruns.
        bus.ready_i = 1'b0;
        send_frame(9'h1BC, 9'h0AA, 9'h055, 1'b0, 1'b0);
        send_frame(9'h0FF, 9'h100, 9'h001, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("t4_hold", bus.data_o, 32'h06F1_5455);
        bus.ready_i = 1'b1;
        idle(3);

        // Reset in the middle of the data bits, then a fresh frame.
        drive_bit(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) drive_bit(i[0], 1'b1, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0; data_i = 1'b0; line_busy = 1'b0; ev_stop = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(9'h000, 9'h1FF, 9'h13C, 1'b0, 1'b0);
        expect_out("t5", 32'h0003_FF3C, 3'b011);
        idle(3);

`ifdef DESER_PARITY_CHECK_EN
        // Flipped parity bit must be rejected.
        send_frame(9'h1BC, 9'h0AA, 9'h055, 1'b0, 1'b1);
        idle(3);
`endif

        // Randomised frames, errors, gaps and consumer stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send_frame(9'($urandom), 9'($urandom), 9'($urandom),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        bus.ready_i = 1'b1;
        idle(6);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
